// File: rtl/timer_irq_source.sv
// Memory-mapped interval timer: TH reload, TL up-counter, TCON {irq_flag, irq_en, cnt_en}.
// Define TIMER_PRESCALE_EN to advance TL once per PRESCALE_DIV clocks instead of every clock.
module timer_irq_source #(
  parameter logic [31:0] ADDR_BASE    = 32'h4000_0000,
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [31:0] AddrTh   = ADDR_BASE;
  localparam logic [31:0] AddrTl   = ADDR_BASE + 32'd4;
  localparam logic [31:0] AddrTcon = ADDR_BASE + 32'd8;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic        cnt_en_q, cnt_en_d;
  logic        irq_en_q, irq_en_d;
  logic        irq_flag_q, irq_flag_d;

  logic sel_th, sel_tl, sel_tcon;
  logic wr_th, wr_tl, wr_tcon;
  logic tick, overflow;

  assign sel_th   = (addr == AddrTh);
  assign sel_tl   = (addr == AddrTl);
  assign sel_tcon = (addr == AddrTcon);

  assign wr_th   = MemWrite & sel_th;
  assign wr_tl   = MemWrite & sel_tl;
  assign wr_tcon = MemWrite & sel_tcon;

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned    PreW    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE_DIV - 1);

  logic [PreW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (wr_tcon) begin
      pre_d = '0;
    end else if (cnt_en_q) begin
      pre_d = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = cnt_en_q & (pre_q == PreLast);
`else
  // PRESCALE_DIV has no effect without the prescaler.
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE_DIV;
  assign tick = cnt_en_q;
`endif

  always_comb begin
    overflow = tick & (tl_q == 32'hFFFF_FFFF);

    th_d = wr_th ? wdata : th_q;

    // A TL store beats both the increment and the reload; a reload uses the pre-write TH.
    tl_d = tl_q;
    if (wr_tl) begin
      tl_d = wdata;
    end else if (overflow) begin
      tl_d = th_q;
    end else if (tick) begin
      tl_d = tl_q + 32'd1;
    end

    cnt_en_d   = wr_tcon ? wdata[0] : cnt_en_q;
    irq_en_d   = wr_tcon ? wdata[1] : irq_en_q;
    irq_flag_d = wr_tcon ? wdata[2] : irq_flag_q;
    // A request raised by this overflow must survive a simultaneous software clear.
    if (overflow & ~wr_tl & irq_en_d) begin
      irq_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q       <= 32'h0;
      tl_q       <= 32'h0;
      cnt_en_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_flag_q <= 1'b0;
    end else begin
      th_q       <= th_d;
      tl_q       <= tl_d;
      cnt_en_q   <= cnt_en_d;
      irq_en_q   <= irq_en_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (MemRead) begin
      if (sel_th) begin
        rdata = th_q;
      end else if (sel_tl) begin
        rdata = tl_q;
      end else if (sel_tcon) begin
        rdata = {29'h0, irq_flag_q, irq_en_q, cnt_en_q};
      end
    end
  end

  assign irq = irq_flag_q & irq_en_q;

endmodule
